// File: rtl/sqrt_job_sequencer_if.sv
// Handshake bundle for sqrt_job_sequencer: operand stream in,
// calculator start/operand/root, result stream out.
interface sqrt_job_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       S;
    logic [7:0] X;
    logic [7:0] sqrt_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_operand;
    logic       out_err;

    modport master (
        output in_valid, in_data, sqrt_in, out_ready,
        input  in_ready, S, X, out_valid, out_data,
        input  out_operand, out_err
    );

    modport slave (
        input  in_valid, in_data, sqrt_in, out_ready,
        output in_ready, S, X, out_valid, out_data,
        output out_operand, out_err
    );
endinterface

// File: rtl/sqrt_job_sequencer.sv
// Queues operands and runs them one at a time through a fixed-latency sqrt unit.
// Optional range check of the returned root: define SQRT_SEQ_CHECK_EN.
module sqrt_job_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int WAIT_CYCLES = 36
) (
    input logic                 Clock,
    input logic                 Reset,
    sqrt_job_sequencer_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [CW-1:0] wait_q;
    logic [7:0]    x_q;
    logic [7:0]    data_q;
    logic [7:0]    operand_q;
    logic          push;
    logic          pop;
    logic          load_x;
    logic          capture;
    logic          empty;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign bus.in_ready = count_q < (AW+1)'(FIFO_DEPTH);
    assign push         = bus.in_valid & bus.in_ready;
    assign empty        = (count_q == '0);

    assign bus.S           = (state_q == ISSUE);
    assign bus.X           = x_q;
    assign bus.out_valid   = (state_q == HOLD);
    assign bus.out_data    = data_q;
    assign bus.out_operand = operand_q;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load_x  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = ISSUE;
                    load_x  = 1'b1;
                end
            end
            ISSUE: begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            x_q       <= '0;
            data_q    <= '0;
            operand_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            // X is loaded on entry to ISSUE so it is valid alongside the S pulse.
            if (load_x) begin
                x_q <= mem[rd_ptr_q];
            end
            if (pop) begin
                wait_q <= CW'(WAIT_CYCLES - 1);
            end else if (state_q == WAIT && wait_q != '0) begin
                wait_q <= wait_q - CW'(1);
            end
            if (capture) begin
                data_q    <= bus.sqrt_in;
                operand_q <= x_q;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

`ifdef SQRT_SEQ_CHECK_EN
    logic [16:0] r17;
    logic [16:0] op17;
    logic [16:0] lo17;
    logic [16:0] hi17;
    logic        range_bad;
    logic        err_q;

    // 17 bits holds (255+1)^2 without overflow.
    always_comb begin
        r17       = {9'd0, bus.sqrt_in};
        op17      = {9'd0, x_q};
        lo17      = r17 * r17;
        hi17      = (r17 + 17'd1) * (r17 + 17'd1);
        range_bad = !((lo17 <= op17) && (op17 < hi17));
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            err_q <= 1'b0;
        end else if (capture) begin
            err_q <= range_bad;
        end
    end

    assign bus.out_err = err_q;
`else
    assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// Directed bench for sqrt_job_sequencer with a behavioural sqrt calculator.
// Expected out_err follows SQRT_SEQ_CHECK_EN as compiled.
module tb_sqrt_job_sequencer;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    bit   force_en;
    logic [7:0] force_val;
    logic [7:0] got_op [8];
    logic [7:0] got_data [8];
    int   got_n;

`ifdef SQRT_SEQ_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    sqrt_job_sequencer_if bus ();

    sqrt_job_sequencer #(
        .FIFO_DEPTH (4),
        .WAIT_CYCLES(36)
    ) dut (
        .Clock(clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] isqrt(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 1; i < 16; i++) begin
            if (i * i <= int'(v)) r = 8'(i);
        end
        return r;
    endfunction

    always_comb bus.sqrt_in = force_en ? force_val : isqrt(bus.X);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        int w;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        w = 0;
        while (!bus.in_ready && w < 200) begin
            tick();
            w++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL push_ready got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok, output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        ok = (bus.out_valid === 1'b1);
    endtask

    task automatic collect(input int n);
        bit acc;
        got_n = 0;
        for (int c = 0; c < n * 50 && got_n < n; c++) begin
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                got_op[got_n]   = bus.out_operand;
                got_data[got_n] = bus.out_data;
                got_n++;
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        force_en      = 1'b0;
        force_val     = '0;
        repeat (3) tick();
        vectors += 7;
        if (bus.S !== 1'b0) begin
            miscompares++; $display("FAIL rst_S got %b want 0", bus.S);
        end
        if (bus.X !== 8'd0) begin
            miscompares++; $display("FAIL rst_X got %0d want 0", bus.X);
        end
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
        end
        if (bus.out_data !== 8'd0) begin
            miscompares++; $display("FAIL rst_out_data got %0d want 0", bus.out_data);
        end
        if (bus.out_operand !== 8'd0) begin
            miscompares++; $display("FAIL rst_out_operand got %0d want 0", bus.out_operand);
        end
        if (bus.out_err !== 1'b0) begin
            miscompares++; $display("FAIL rst_out_err got %b want 0", bus.out_err);
        end
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
        end
        // Operand offered across release: must be taken on the first edge.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd200;
        rst_n        = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.S !== 1'b0) begin
            miscompares++; $display("FAIL basic_S_early got %b want 0", bus.S);
        end
        tick();
        vectors += 2;
        if (bus.S !== 1'b1) begin
            miscompares++; $display("FAIL basic_S got %b want 1", bus.S);
        end
        if (bus.X !== 8'd200) begin
            miscompares++; $display("FAIL basic_X got %0d want 200", bus.X);
        end
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                vectors++;
                if (bus.S !== 1'b0) begin
                    miscompares++; $display("FAIL basic_S_width got %b want 0", bus.S);
                end
            end
        end while (bus.out_valid !== 1'b1 && n < 60);
        vectors += 4;
        if (n != 37) begin
            miscompares++; $display("FAIL basic_latency got %0d want 37", n);
        end
        if (bus.out_data !== 8'd14) begin
            miscompares++; $display("FAIL basic_data got %0d want 14", bus.out_data);
        end
        if (bus.out_operand !== 8'd200) begin
            miscompares++; $display("FAIL basic_operand got %0d want 200", bus.out_operand);
        end
        if (bus.out_err !== 1'b0) begin
            miscompares++; $display("FAIL basic_err got %b want 0", bus.out_err);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_valid_fall got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_check();
        bit ok;
        int n;
        bus.out_ready = 1'b1;
        force_en  = 1'b1;
        force_val = 8'd15;
        push(8'd200);
        wait_valid(ok, n);
        vectors += 2;
        if (!ok) begin
            miscompares++; $display("FAIL chk200_timeout got %0d want valid", n);
        end
        if (bus.out_err !== CHECK_ON) begin
            miscompares++; $display("FAIL chk200_err got %b want %b", bus.out_err, CHECK_ON);
        end
        tick();
        force_val = 8'd1;
        push(8'd0);
        wait_valid(ok, n);
        vectors += 3;
        if (!ok) begin
            miscompares++; $display("FAIL chk0_timeout got %0d want valid", n);
        end
        if (bus.out_err !== CHECK_ON) begin
            miscompares++; $display("FAIL chk0_err got %b want %b", bus.out_err, CHECK_ON);
        end
        if (bus.out_data !== 8'd1 || bus.out_operand !== 8'd0) begin
            miscompares++;
            $display("FAIL chk0_data got %0d/%0d want 1/0", bus.out_data, bus.out_operand);
        end
        tick();
        force_en = 1'b0;
        push(8'd255);
        wait_valid(ok, n);
        vectors += 2;
        if (bus.out_data !== 8'd15) begin
            miscompares++; $display("FAIL chk255_data got %0d want 15", bus.out_data);
        end
        if (bus.out_err !== 1'b0) begin
            miscompares++; $display("FAIL chk255_err got %b want 0", bus.out_err);
        end
        tick();
    endtask

    task automatic test_hold_stall();
        bit ok;
        int n;
        bus.out_ready = 1'b0;
        push(8'd100);
        wait_valid(ok, n);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL hold_timeout got %0d want valid", n);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd10 ||
                bus.out_operand !== 8'd100 || bus.S !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_stable cyc %0d got v=%b d=%0d op=%0d S=%b want 1/10/100/0",
                         i, bus.out_valid, bus.out_data, bus.out_operand, bus.S);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [6];
        ops[0] = 8'd100; ops[1] = 8'd1;  ops[2] = 8'd4;
        ops[3] = 8'd9;   ops[4] = 8'd16; ops[5] = 8'd25;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_data = ops[i];
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++; $display("FAIL b2b_ready %0d got %b want 1", i, bus.in_ready);
            end
            tick();
        end
        bus.in_data = ops[5];
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.in_ready !== 1'b0) begin
                miscompares++; $display("FAIL b2b_full %0d got %b want 0", i, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        collect(6);
        vectors += 2;
        if (got_n != 6) begin
            miscompares++; $display("FAIL b2b_count got %0d want 6", got_n);
        end
        if (bus.in_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_last_push got %b want 0", bus.in_valid);
        end
        for (int i = 0; i < got_n; i++) begin
            vectors++;
            if (got_op[i] !== ops[i] || got_data[i] !== isqrt(ops[i])) begin
                miscompares++;
                $display("FAIL b2b_order %0d got %0d/%0d want %0d/%0d",
                         i, got_op[i], got_data[i], ops[i], isqrt(ops[i]));
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        bit seen;
        int n;
        bus.out_ready = 1'b1;
        push(8'd7);
        push(8'd8);
        push(8'd9);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        vectors += 4;
        if (bus.S !== 1'b0) begin
            miscompares++; $display("FAIL midrst_S got %b want 0", bus.S);
        end
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL midrst_valid got %b want 0", bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL midrst_ready got %b want 1", bus.in_ready);
        end
        if (bus.X !== 8'd0) begin
            miscompares++; $display("FAIL midrst_X got %0d want 0", bus.X);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.S === 1'b1 || bus.out_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++; $display("FAIL midrst_quiet got activity want none");
        end
        push(8'd49);
        wait_valid(ok, n);
        vectors++;
        if (!ok || bus.out_data !== 8'd7 || bus.out_operand !== 8'd49) begin
            miscompares++;
            $display("FAIL midrst_next got %b/%0d/%0d want 1/7/49",
                     ok, bus.out_data, bus.out_operand);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] ops [5];
        ops[0] = 8'd11; ops[1] = 8'd22; ops[2] = 8'd33;
        ops[3] = 8'd44; ops[4] = 8'd55;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = ops[i];
            if (i == 2) begin
                vectors++;
                if (bus.S !== 1'b1) begin
                    miscompares++; $display("FAIL wrap_issue got %b want 1", bus.S);
                end
            end
            tick();
            if (i == 2) begin
                vectors++;
                if (dut.count_q !== 3'd2) begin
                    miscompares++; $display("FAIL wrap_count got %0d want 2", dut.count_q);
                end
            end
        end
        bus.in_valid = 1'b0;
        collect(5);
        vectors++;
        if (got_n != 5) begin
            miscompares++; $display("FAIL wrap_results got %0d want 5", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            vectors++;
            if (got_op[i] !== ops[i] || got_data[i] !== isqrt(ops[i])) begin
                miscompares++;
                $display("FAIL wrap_order %0d got %0d/%0d want %0d/%0d",
                         i, got_op[i], got_data[i], ops[i], isqrt(ops[i]));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_check();
        test_hold_stall();
        test_back_to_back();
        test_reset_mid_wait();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
